ascii_cell_scheduler: RTL and testbench
=======================================

ASCII_CELL_SCHEDULER -- requirements
Module: ascii_cell_scheduler

Interface
REQ-001 SHALL have parameter IMG_W, default 320, image width in pixels (multiple of 8).
REQ-002 SHALL have parameter IMG_H, default 240, image height in pixels (multiple of 8).
REQ-003 SHALL have parameter ADDR_W, default 11, character address width (>= clog2(IMG_W/8*IMG_H/8)).
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port pix_valid, input, 1, gray pixel offered.
REQ-007 SHALL have port pix_sof, input, 1, qualifies pixel as frame pixel (0,0).
REQ-008 SHALL have port pix_gray, input, 8, gray level, raster order.
REQ-009 SHALL have port pix_ready, output, 1, pixel accepted when pix_valid && pix_ready.
REQ-010 SHALL have port ch_valid, output, 1, character write offered.
REQ-011 SHALL have port ch_ready, input, 1, character sink accepts.
REQ-012 SHALL have port ch_addr, output, ADDR_W, cell_row*(IMG_W/8)+cell_col.
REQ-013 SHALL have port ch_data, output, 8, ASCII code.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse at end of frame.

Function
REQ-015 SHALL run states IDLE (wait for pix_sof), ACCUM (consume pixels), DONE (one cycle, pulse frame_done, return to IDLE).
REQ-016 In IDLE, SHALL hold pix_ready=1 and discard accepted pixels with pix_sof=0.
REQ-017 SHALL track pixel x (0..IMG_W-1) and y (0..IMG_H-1); x wraps to 0 and y increments on each accepted pixel with x=IMG_W-1.
REQ-018 SHALL keep IMG_W/8 accumulators of 14 bits, one per cell column; on a pixel with y%8==0 and x%8==0, load accumulator with pix_gray, otherwise add pix_gray.
REQ-019 On acceptance of the pixel with x%8==7 and y%8==7, SHALL compute avg = (acc + pix_gray)>>6 and register ch_valid=1, ch_addr, ch_data the next cycle.
REQ-020 Mapping of avg: <26 '@', <52 '%', <78 '#', <103 '*', <129 '+', <154 '=', <180 '-', <205 ':', <231 '.', else ' ' (0x20).
REQ-021 ch_valid, ch_addr, ch_data SHALL remain stable until ch_valid && ch_ready.
REQ-022 pix_ready SHALL equal !ch_valid || ch_ready in ACCUM (one-deep output slot, no pixel loss).
REQ-023 Accepted pixel with pix_sof=1 in ACCUM SHALL abort the frame: x,y restart as (0,0) with that pixel, pending ch_valid is not cleared, no frame_done.
REQ-024 After last pixel (IMG_W-1, IMG_H-1) accepted, SHALL enter DONE only after the final character handshake completes; frame_done asserts that cycle for exactly one clock.
REQ-025 Characters SHALL be emitted in address order 0..(IMG_W/8*IMG_H/8)-1, exactly once per complete frame.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, x=y=0, ch_valid=0, ch_addr=0, ch_data=0x20, frame_done=0; pix_ready=1 in IDLE after reset.
REQ-027 Reset mid-frame SHALL drop any pending character; accumulator contents need not be cleared (loaded by REQ-018 rule).

Verification
REQ-028 All-zero 320x240 frame, ch_ready=1 -> 1200 writes, addr 0..1199, data '@', frame_done one pulse after last handshake.
REQ-029 All-255 frame -> 1200 writes of 0x20; then frame with first cell all 25 and next cell all 26 -> addr0 '@', addr1 '%'.
REQ-030 Gradient cells at avg 230/231 -> '.' then ' '; avg 128/129 -> '+' then '='.
REQ-031 ch_ready low 5 cycles while ch_valid=1 -> pix_ready=0 those cycles, ch_addr/ch_data stable, no pixel dropped, sequence unchanged.
REQ-032 pix_sof reasserted at pixel (100,50) -> addressing restarts at 0, no frame_done for aborted frame, new frame completes normally.
REQ-033 rst_n pulsed low mid-frame with ch_valid=1 -> ch_valid=0 immediately (async), next pix_sof frame yields full correct 1200 writes.

Source files
------------

// File: rtl/ascii_cell_scheduler.sv
// ascii_cell_scheduler: averages 8x8 gray cells of a raster frame and emits one ASCII glyph per cell.
module ascii_cell_scheduler #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [7:0]        pix_gray,
    output logic              pix_ready,
    output logic              ch_valid,
    input  logic              ch_ready,
    output logic [ADDR_W-1:0] ch_addr,
    output logic [7:0]        ch_data,
    output logic              frame_done
);
    localparam int COLS = IMG_W / 8;
    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state, state_nx;

    logic [XW-1:0]     x, px;
    logic [YW-1:0]     y, py;
    logic              last, take, proc, hs, cell_end, row_end;
    logic [13:0]       acc [COLS];
    logic [13:0]       sum;
    logic [7:0]        avg, glyph;
    logic [ADDR_W-1:0] addr;

    assign take      = pix_valid && pix_ready;
    assign hs        = ch_valid && ch_ready;
    assign pix_ready = (state == IDLE) || (state == ACCUM && (!ch_valid || ch_ready));
    // A sof pixel always starts a frame at (0,0); other pixels only count mid-frame.
    assign proc      = take && (pix_sof || (state == ACCUM && !last));
    assign px        = pix_sof ? '0 : x;
    assign py        = pix_sof ? '0 : y;
    assign cell_end  = px[2:0] == 3'd7 && py[2:0] == 3'd7;
    assign row_end   = px == XW'(IMG_W - 1);
    assign sum       = acc[px[XW-1:3]] + 14'(pix_gray);
    assign avg       = 8'(sum >> 6);
    assign addr      = ADDR_W'(py >> 3) * ADDR_W'(COLS) + ADDR_W'(px >> 3);
    assign frame_done = state == DONE;

    always_comb begin
        glyph = avg < 8'd26  ? 8'h40 :
                avg < 8'd52  ? 8'h25 :
                avg < 8'd78  ? 8'h23 :
                avg < 8'd103 ? 8'h2A :
                avg < 8'd129 ? 8'h2B :
                avg < 8'd154 ? 8'h3D :
                avg < 8'd180 ? 8'h2D :
                avg < 8'd205 ? 8'h3A :
                avg < 8'd231 ? 8'h2E : 8'h20;
    end

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE && proc)                              ? ACCUM :
                   (state == ACCUM && !(take && pix_sof) && last && hs) ? DONE  :
                   (state == DONE)                                      ? IDLE  : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x        <= '0;
            y        <= '0;
            last     <= 1'b0;
            ch_valid <= 1'b0;
            ch_addr  <= '0;
            ch_data  <= 8'h20;
        end else begin
            state <= state_nx;
            if (proc) begin
                x    <= row_end ? '0 : px + 1'b1;
                y    <= row_end ? (py == YW'(IMG_H - 1) ? '0 : py + 1'b1) : py;
                last <= row_end && py == YW'(IMG_H - 1);
            end else if (state == DONE) begin
                last <= 1'b0;
            end
            if (proc && cell_end) begin
                ch_valid <= 1'b1;
                ch_addr  <= addr;
                ch_data  <= glyph;
            end else if (hs) begin
                ch_valid <= 1'b0;
            end
        end
    end

    // Accumulators are reloaded at each cell's first pixel, so they need no reset.
    always_ff @(posedge clk) begin
        if (proc)
            acc[px[XW-1:3]] <= (px[2:0] == 3'd0 && py[2:0] == 3'd0) ? 14'(pix_gray) : sum;
    end
endmodule

// File: tb/tb_ascii_cell_scheduler.sv
// tb_ascii_cell_scheduler: directed checks on a 32x16 image (4x2 cells, addresses 0..7).
module tb_ascii_cell_scheduler;
    localparam int W = 32;
    localparam int H = 16;

    logic        clk = 0;
    logic        rst_n;
    logic        pix_valid, pix_sof, pix_ready;
    logic [7:0]  pix_gray;
    logic        ch_valid, ch_ready, frame_done;
    logic [10:0] ch_addr;
    logic [7:0]  ch_data;

    int checks = 0;
    int errors = 0;
    int q_addr[$];
    int q_data[$];
    int ncnt = 0, last_hs = 0, fd_at = 0, fd_count = 0;
    int base[8];
    int jit[8];
    int exp_ch[8];
    int prev;

    ascii_cell_scheduler #(.IMG_W(W), .IMG_H(H), .ADDR_W(11)) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_gray(pix_gray), .pix_ready(pix_ready), .ch_valid(ch_valid),
        .ch_ready(ch_ready), .ch_addr(ch_addr), .ch_data(ch_data),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Inputs change only at posedge+1, so valid&&ready seen at a negedge is a handshake at the next edge.
    always @(negedge clk) begin
        ncnt++;
        if (ch_valid && ch_ready) begin
            q_addr.push_back(int'(ch_addr));
            q_data.push_back(int'(ch_data));
            last_hs = ncnt;
        end
        if (frame_done) begin
            fd_count++;
            fd_at = ncnt;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] gray_of(input int i);
        int xx = i % W;
        int yy = i / W;
        int c  = (yy / 8) * (W / 8) + xx / 8;
        return 8'(base[c] + ((xx % 2 == 1) ? jit[c] : 0));
    endfunction

    task automatic px(input logic [7:0] g, input logic s);
        int n = 0;
        pix_valid = 1; pix_gray = g; pix_sof = s;
        @(negedge clk);
        while (!pix_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $error("FAIL pix_timeout: pix_ready low for %0d cycles, required 1", n);
        end
        @(posedge clk); #1;
        pix_valid = 0; pix_sof = 0;
    endtask

    task automatic send_range(input int a, input int b);
        for (int i = a; i < b; i++) px(gray_of(i), i == 0);
    endtask

    task automatic wait_done(input string tag, input int p);
        int n = 0;
        while (fd_count == p && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_done_count"}, fd_count, p + 1);
        if (fd_count != p) chk({tag, "_done_gap"}, fd_at - last_hs, 1);
    endtask

    task automatic check_frame(input string tag, input int start);
        chk({tag, "_writes"}, q_addr.size(), start + 8);
        for (int i = 0; i < 8; i++)
            if (start + i < q_addr.size()) begin
                chk({tag, "_addr"}, q_addr[start + i], i);
                chk({tag, "_data"}, q_data[start + i], exp_ch[i]);
            end
    endtask

    initial begin
        rst_n = 0; pix_valid = 0; pix_sof = 0; pix_gray = 0; ch_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ch_valid", ch_valid, 0);
        chk("rst_ch_addr", ch_addr, 0);
        chk("rst_ch_data", ch_data, 8'h20);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_pix_ready", pix_ready, 1);
        rst_n = 1;
        @(posedge clk); #1;
        chk("idle_pix_ready", pix_ready, 1);

        base = '{0, 0, 0, 0, 0, 0, 0, 0};
        jit  = '{0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) px(8'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_discard_writes", q_addr.size(), 0);
        chk("idle_discard_done", fd_count, 0);

        exp_ch = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
        prev = fd_count;
        send_range(0, W * H);
        wait_done("zero", prev);
        check_frame("zero", 0);
        q_addr.delete(); q_data.delete();

        base = '{255, 255, 255, 255, 255, 255, 255, 255};
        exp_ch = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
        prev = fd_count;
        send_range(0, W * H);
        wait_done("white", prev);
        check_frame("white", 0);
        q_addr.delete(); q_data.delete();

        // Cell 2 alternates 230/231: average 230.5 truncates to 230.
        base = '{25, 26, 230, 231, 128, 129, 51, 52};
        jit  = '{0, 0, 1, 0, 0, 0, 0, 0};
        exp_ch = '{8'h40, 8'h25, 8'h2E, 8'h20, 8'h2B, 8'h3D, 8'h25, 8'h23};
        prev = fd_count;
        send_range(0, W * H);
        wait_done("thresh", prev);
        check_frame("thresh", 0);
        q_addr.delete(); q_data.delete();

        prev = fd_count;
        send_range(0, 7 * W + 8);
        chk("stall_ch_valid_set", ch_valid, 1);
        ch_ready = 0;
        pix_valid = 1; pix_gray = gray_of(7 * W + 8); pix_sof = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_pix_ready", pix_ready, 0);
            chk("stall_ch_valid", ch_valid, 1);
            chk("stall_ch_addr", ch_addr, 0);
            chk("stall_ch_data", ch_data, 8'h40);
            @(posedge clk); #1;
        end
        chk("stall_no_write", q_addr.size(), 0);
        ch_ready = 1;
        send_range(7 * W + 8, W * H);
        wait_done("stall", prev);
        check_frame("stall", 0);
        q_addr.delete(); q_data.delete();

        prev = fd_count;
        send_range(0, 9 * W + 10);
        chk("abort_no_done", fd_count, prev);
        send_range(0, W * H);
        wait_done("abort", prev);
        chk("abort_writes", q_addr.size(), 12);
        if (q_addr.size() >= 5) begin
            chk("abort_old_addr3", q_addr[3], 3);
            chk("abort_restart_addr", q_addr[4], 0);
        end
        check_frame("abort", 4);
        q_addr.delete(); q_data.delete();

        send_range(0, 7 * W + 8);
        ch_ready = 0;
        @(negedge clk);
        chk("rstmid_ch_valid_before", ch_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("rstmid_ch_valid", ch_valid, 0);
        chk("rstmid_ch_data", ch_data, 8'h20);
        chk("rstmid_pix_ready", pix_ready, 1);
        chk("rstmid_frame_done", frame_done, 0);
        @(posedge clk); #1;
        rst_n = 1; ch_ready = 1;
        prev = fd_count;
        send_range(0, W * H);
        wait_done("rstmid", prev);
        check_frame("rstmid", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
